// File: rtl/snes_controller_emulator.sv
// SNES gamepad responder: latches a 12-button frame on snes_latch and
// shifts it out active-low on snes_data, one bit per snes_pulse edge.
module snes_controller_emulator #(
  parameter int NUM_BITS       = 16,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  input  logic [11:0] buttons,
  input  logic        snes_latch,
  input  logic        snes_pulse,
  output logic        snes_data,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [7:0]  latch_count
);

  localparam int CW = $clog2(NUM_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCHED,
    S_SHIFT
  } state_t;

  logic latch_s1_q, latch_s2_q, latch_h_q;
  logic pulse_s1_q, pulse_s2_q, pulse_h_q;

  state_t               state_q, state_d;
  logic [NUM_BITS-1:0]  shift_q, shift_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [7:0]           latch_count_q, latch_count_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_abort_q, frame_abort_d;

  logic                 latch_rise, latch_fall, pulse_rise;
  logic [NUM_BITS-1:0]  load_val;

  // Two-flop synchronizers plus history flops for edge detection
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      latch_s1_q <= 1'b0;
      latch_s2_q <= 1'b0;
      latch_h_q  <= 1'b0;
      pulse_s1_q <= 1'b0;
      pulse_s2_q <= 1'b0;
      pulse_h_q  <= 1'b0;
    end else begin
      latch_s1_q <= snes_latch;
      latch_s2_q <= latch_s1_q;
      latch_h_q  <= latch_s2_q;
      pulse_s1_q <= snes_pulse;
      pulse_s2_q <= pulse_s1_q;
      pulse_h_q  <= pulse_s2_q;
    end
  end

  assign latch_rise = latch_s2_q & ~latch_h_q;
  assign latch_fall = ~latch_s2_q & latch_h_q;
  assign pulse_rise = pulse_s2_q & ~pulse_h_q;

  // Frame image: inverted buttons, B at the MSB, padding bits idle high
  always_comb begin
    load_val = '1;
    load_val[NUM_BITS-1 -: 12] = ~buttons;
  end

  // Next-state, shift register and counter control
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_d         = tmo_q;
    latch_count_d = latch_count_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        shift_d = '1;
        if (latch_rise) begin
          state_d       = S_LATCHED;
          shift_d       = load_val;
          latch_count_d = latch_count_q + 8'd1;
        end
      end
      S_LATCHED: begin
        if (latch_fall) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
          tmo_d     = '0;
        end else if (latch_s2_q) begin
          shift_d = load_val;
        end
      end
      S_SHIFT: begin
        if (latch_rise) begin
          state_d       = S_LATCHED;
          shift_d       = load_val;
          latch_count_d = latch_count_q + 8'd1;
          frame_abort_d = 1'b1;
        end else if (pulse_rise) begin
          shift_d   = {shift_q[NUM_BITS-2:0], 1'b1};
          bit_cnt_d = bit_cnt_q + CW'(1);
          tmo_d     = '0;
          if (bit_cnt_q == CW'(NUM_BITS - 1)) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
          state_d       = S_IDLE;
          shift_d       = '1;
          frame_abort_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        shift_d = '1;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q       <= S_IDLE;
      shift_q       <= '1;
      bit_cnt_q     <= '0;
      tmo_q         <= '0;
      latch_count_q <= '0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_q         <= tmo_d;
      latch_count_q <= latch_count_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign snes_data   = shift_q[NUM_BITS-1];
  assign busy        = (state_q == S_LATCHED) || (state_q == S_SHIFT);
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign latch_count = latch_count_q;

endmodule
